// File: rtl/ysyx_23060201_lsu_if.sv
// Bus bundle between the execute stage, the LSU, the memory stage and write-back.
//
// Handshake rules for both the in_* and out_* channels:
// a transfer happens on a rising clk edge where valid and ready are both high.
// Once valid is raised, the producer holds valid and its payload unchanged until that
// transfer. ready may depend on the consumer's state but never on valid in the same cycle.
// The mem_* strobes are single-cycle commands. mem_rdata is combinational and is
// sampled in the same cycle as mem_ren.
interface ysyx_23060201_lsu_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // request from execute
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_ren;
  logic                  in_wen;
  logic [2:0]            in_funct3;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [DATA_WIDTH-1:0] in_wdata;
  logic [4:0]            in_rd;
  // memory stage
  logic                  mem_ren;
  logic                  mem_wen;
  logic [ADDR_WIDTH-1:0] mem_raddr;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [7:0]            mem_rmask;
  logic [7:0]            mem_wmask;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  // result to write-back
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_rdata;
  logic [4:0]            out_rd;
  logic                  out_misalign;

  // LSU side
  modport slave (
    input  in_valid, in_ren, in_wen, in_funct3, in_addr, in_wdata, in_rd,
    output in_ready,
    output mem_ren, mem_wen, mem_raddr, mem_waddr, mem_rmask, mem_wmask, mem_wdata,
    input  mem_rdata,
    output out_valid, out_rdata, out_rd, out_misalign,
    input  out_ready
  );

  // environment side: execute, memory and write-back stages
  modport master (
    output in_valid, in_ren, in_wen, in_funct3, in_addr, in_wdata, in_rd,
    input  in_ready,
    input  mem_ren, mem_wen, mem_raddr, mem_waddr, mem_rmask, mem_wmask, mem_wdata,
    output mem_rdata,
    input  out_valid, out_rdata, out_rd, out_misalign,
    output out_ready
  );
endinterface

// File: rtl/ysyx_23060201_lsu.sv
// Load/store unit. Each request takes one IDLE -> ACCESS -> RESP pass.
// Requests that are misaligned, or that are neither a load nor a store, skip ACCESS.
// They go straight to RESP and never touch memory.
module ysyx_23060201_lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  ysyx_23060201_lsu_if.slave   bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_next;

  // captured request
  logic                  ren_q;
  logic                  wen_q;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [4:0]            rd_q;
  // captured result
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  misalign_q;

  // decode of the incoming request, used only at acceptance
  logic [1:0] in_off;
  logic       in_is_b;
  logic       in_is_h;
  logic       in_is_w;
  logic       in_access;
  logic       in_misalign;
  logic       in_fire;

  // access-cycle datapath
  logic [1:0]            off_q;
  logic [3:0]            mask_base;
  logic [3:0]            mask4;
  logic                  load_q;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] load_ext;

  assign in_off      = bus.in_addr[1:0];
  assign in_is_b     = (bus.in_funct3[1:0] == 2'b00);
  assign in_is_h     = (bus.in_funct3[1:0] == 2'b01);
  assign in_is_w     = !in_is_b && !in_is_h;
  assign in_access   = bus.in_ren || bus.in_wen;
  assign in_misalign = in_access && ((in_is_h && in_off[0]) || (in_is_w && (in_off != 2'b00)));
  assign in_fire     = bus.in_valid && (state == IDLE);

  assign off_q  = addr_q[1:0];
  // a store wins when both ren and wen are set, so the read is suppressed
  assign load_q = ren_q && !wen_q;

  assign dbg_state = state;

  // state register; reset drops back to IDLE immediately, killing any strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          if (in_misalign || !in_access) state_next = RESP;
          else                           state_next = ACCESS;
        end
      end
      ACCESS: state_next = RESP;
      RESP: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // byte-lane mask: base size shifted to the addressed lane
  always_comb begin
    mask_base = 4'b1111;
    case (funct3_q[1:0])
      2'b00:   mask_base = 4'b0001;
      2'b01:   mask_base = 4'b0011;
      default: mask_base = 4'b1111;
    endcase
    mask4 = mask_base << off_q;
  end

  // load alignment and extension of the combinational read data
  always_comb begin
    shifted  = bus.mem_rdata >> {off_q, 3'b000};
    load_ext = shifted;
    case (funct3_q)
      3'b000:  load_ext = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // handshake and memory strobes; every mem_* output is zero outside its strobe
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == RESP);
    bus.mem_ren   = 1'b0;
    bus.mem_wen   = 1'b0;
    bus.mem_raddr = '0;
    bus.mem_waddr = '0;
    bus.mem_rmask = 8'h00;
    bus.mem_wmask = 8'h00;
    bus.mem_wdata = '0;
    if (state == ACCESS) begin
      if (wen_q) begin
        bus.mem_wen   = 1'b1;
        bus.mem_waddr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        bus.mem_wmask = {4'b0000, mask4};
        bus.mem_wdata = wdata_q << {off_q, 3'b000};
      end else if (ren_q) begin
        bus.mem_ren   = 1'b1;
        bus.mem_raddr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        bus.mem_rmask = {4'b0000, mask4};
      end
    end
  end

  // request capture at acceptance, load result capture at the end of ACCESS
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ren_q      <= 1'b0;
      wen_q      <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= 5'd0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      if (in_fire) begin
        ren_q      <= bus.in_ren;
        wen_q      <= bus.in_wen;
        funct3_q   <= bus.in_funct3;
        addr_q     <= bus.in_addr;
        wdata_q    <= bus.in_wdata;
        rd_q       <= bus.in_rd;
        rdata_q    <= '0;
        misalign_q <= in_misalign;
      end else if (state == ACCESS && load_q) begin
        rdata_q <= load_ext;
      end
    end
  end

  assign bus.out_rdata    = rdata_q;
  assign bus.out_rd       = rd_q;
  assign bus.out_misalign = misalign_q;

endmodule

// File: tb/tb_ysyx_23060201_lsu.sv
// Directed bench for the LSU. The issuing tasks push expected memory commands and
// expected results into queues. A negedge monitor pops and compares them whenever
// the DUT strobes memory or completes a result handshake.
module tb_ysyx_23060201_lsu;
  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ysyx_23060201_lsu_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ysyx_23060201_lsu #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int last_acc = 0;

  logic [37:0]  exp_q[$];      // {misalign, rd, rdata}
  int           lat_q[$];      // expected accept-to-handshake cycles, -1 = skip
  int           acc_q[$];      // accept cycle of each request
  logic [113:0] exp_mem_q[$];  // {ren, wen, raddr, waddr, rmask, wmask, wdata}

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [113:0] mem_exp(input logic ren, input logic wen,
                                           input logic [31:0] addr, input logic [7:0] mask,
                                           input logic [31:0] wdata);
    return {ren, wen, ren ? addr : 32'h0, wen ? addr : 32'h0,
            ren ? mask : 8'h0, wen ? mask : 8'h0, wen ? wdata : 32'h0};
  endfunction

  // monitor: memory commands and result handshakes
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_ren || bus.mem_wen) begin
        if (exp_mem_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_mem_strobe: ren=%0b wen=%0b addr=%0h (t=%0t)",
                   bus.mem_ren, bus.mem_wen, bus.mem_raddr | bus.mem_waddr, $time);
        end else begin
          check("mem_cmd", {bus.mem_ren, bus.mem_wen, bus.mem_raddr, bus.mem_waddr,
                            bus.mem_rmask, bus.mem_wmask, bus.mem_wdata},
                exp_mem_q.pop_front());
        end
      end else begin
        check("mem_idle_zero", {bus.mem_raddr, bus.mem_waddr, bus.mem_rmask,
                                bus.mem_wmask, bus.mem_wdata}, 128'h0);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: rd=%0d rdata=%0h (t=%0t)",
                   bus.out_rd, bus.out_rdata, $time);
        end else begin
          int lat;
          int acc;
          check("result", {bus.out_misalign, bus.out_rd, bus.out_rdata}, exp_q.pop_front());
          lat = lat_q.pop_front();
          acc = acc_q.pop_front();
          if (lat >= 0) check("latency", cyc - acc, lat);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic ren, input logic wen, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                       input logic [31:0] mrdata, input logic [113:0] emem, input logic has_mem,
                       input logic [31:0] erdata, input logic emis, input int elat,
                       input int egap);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: in_ready=0 want 1 for rd=%0d", rd);
      return;
    end
    bus.in_valid  = 1'b1;
    bus.in_ren    = ren;
    bus.in_wen    = wen;
    bus.in_funct3 = f3;
    bus.in_addr   = addr;
    bus.in_wdata  = wdata;
    bus.in_rd     = rd;
    bus.mem_rdata = mrdata;
    if (has_mem) exp_mem_q.push_back(emem);
    exp_q.push_back({emis, rd, erdata});
    lat_q.push_back(elat);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    acc_q.push_back(cyc);
    if (egap > 0) check("issue_gap", cyc - last_acc, egap);
    last_acc = cyc;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_ren    = 1'b0;
    bus.in_wen    = 1'b0;
    bus.in_funct3 = 3'b000;
    bus.in_addr   = '0;
    bus.in_wdata  = '0;
    bus.in_rd     = 5'd0;
    bus.mem_rdata = '0;
    bus.out_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_state", dbg_state, 0);
    check("rst_mem", {bus.mem_ren, bus.mem_wen, bus.mem_raddr, bus.mem_waddr,
                      bus.mem_rmask, bus.mem_wmask, bus.mem_wdata}, 128'h0);
    check("rst_out", {bus.out_misalign, bus.out_rd, bus.out_rdata}, 128'h0);
    rst = 1'b0;

    // LB at offset 3, negative byte
    issue(1, 0, 3'b000, 32'h8000_0003, 32'h0, 5'd5, 32'h80FF_1234,
          mem_exp(1, 0, 32'h8000_0000, 8'h08, 32'h0), 1, 32'hFFFF_FF80, 0, 1, 0);
    // SH at offset 2
    issue(0, 1, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 5'd6, 32'h0,
          mem_exp(0, 1, 32'h8000_0000, 8'h0C, 32'hBEEF_0000), 1, 32'h0, 0, 1, 0);
    // misaligned LW: no strobe, direct to RESP
    issue(1, 0, 3'b010, 32'h8000_0001, 32'h0, 5'd7, 32'h0,
          '0, 0, 32'h0, 1, 0, 0);
    drain();

    // LHU with out_ready held low for 5 cycles
    bus.out_ready = 1'b0;
    issue(1, 0, 3'b101, 32'h8000_0002, 32'h0, 5'd8, 32'h9ABC_0000,
          mem_exp(1, 0, 32'h8000_0000, 8'h0C, 32'h0), 1, 32'h0000_9ABC, 0, -1, 0);
    begin
      int n = 0;
      @(negedge clk);
      while (!bus.out_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_out_rdata", bus.out_rdata, 32'h0000_9ABC);
      check("stall_in_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drain();

    // reset during ACCESS of an SW
    issue(0, 1, 3'b010, 32'h8000_0040, 32'hCAFE_F00D, 5'd17, 32'h0,
          mem_exp(0, 1, 32'h8000_0040, 8'h0F, 32'hCAFE_F00D), 1, 32'h0, 0, -1, 0);
    check("sw_wen_before_rst", bus.mem_wen, 1);
    #1;
    rst = 1'b1;
    #1;
    check("rst_async_wen", bus.mem_wen, 0);
    check("rst_async_wdata", bus.mem_wdata, 32'h0);
    check("rst_async_out_valid", bus.out_valid, 0);
    exp_q.delete();
    lat_q.delete();
    acc_q.delete();
    exp_mem_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);
    check("post_rst_out_valid", bus.out_valid, 0);
    check("post_rst_out", {bus.out_misalign, bus.out_rd, bus.out_rdata}, 128'h0);
    repeat (3) @(negedge clk);

    // back-to-back with out_ready=1: gap 3 after an access, 2 after a direct RESP
    issue(1, 0, 3'b100, 32'h8000_0101, 32'h0, 5'd9, 32'h1234_AB00,
          mem_exp(1, 0, 32'h8000_0100, 8'h02, 32'h0), 1, 32'h0000_00AB, 0, 1, 0);
    issue(1, 0, 3'b001, 32'h8000_0200, 32'h0, 5'd10, 32'h0000_8001,
          mem_exp(1, 0, 32'h8000_0200, 8'h03, 32'h0), 1, 32'hFFFF_8001, 0, 1, 3);
    issue(1, 0, 3'b010, 32'h8000_0304, 32'h0, 5'd11, 32'hDEAD_BEEF,
          mem_exp(1, 0, 32'h8000_0304, 8'h0F, 32'h0), 1, 32'hDEAD_BEEF, 0, 1, 3);
    issue(0, 1, 3'b000, 32'h8000_0011, 32'h0000_00A5, 5'd12, 32'h0,
          mem_exp(0, 1, 32'h8000_0010, 8'h02, 32'h0000_A500), 1, 32'h0, 0, 1, 3);
    issue(0, 0, 3'b000, 32'h8000_0050, 32'hFFFF_FFFF, 5'd13, 32'h0,
          '0, 0, 32'h0, 0, 0, 3);
    issue(1, 1, 3'b010, 32'h8000_0020, 32'h1122_3344, 5'd14, 32'h5555_5555,
          mem_exp(0, 1, 32'h8000_0020, 8'h0F, 32'h1122_3344), 1, 32'h0, 0, 1, 2);
    issue(0, 1, 3'b001, 32'h8000_0003, 32'h0000_FFFF, 5'd15, 32'h0,
          '0, 0, 32'h0, 1, 0, 3);
    issue(1, 0, 3'b001, 32'h8000_0006, 32'h0, 5'd16, 32'h7FFF_0000,
          mem_exp(1, 0, 32'h8000_0004, 8'h0C, 32'h0), 1, 32'h0000_7FFF, 0, 1, 2);
    drain();
    repeat (3) @(negedge clk);
    check("exp_mem_q_empty", exp_mem_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
